// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment scanner: NDIG hex digits share one cathode bus, each slot opens
// with an all-off blanking gap, and digit data is double-buffered and swapped at frame end.
module seg7_scan_controller #(
  parameter int NDIG       = 4,
  parameter int DWELL      = 16,
  parameter int BLANK      = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] digits_in,
  output logic              load_ack,
  output logic              frame_done,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg
);

  localparam int   CW  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int   IW  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);

  localparam logic [NDIG-1:0] AN_OFF  = {NDIG{INV}};
  localparam logic [6:0]      SEG_OFF = {7{INV}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              load_ack_q, load_ack_d;
  logic              frame_done_q, frame_done_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic              last_cnt, last_idx;
  logic [3:0]        nibble;
  logic [NDIG-1:0]   an_onehot;

  // Active-high gfedcba patterns; pin polarity is applied afterwards.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    s = 7'h00;
    case (d)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    cnt_d        = cnt_q + CW'(1);
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    load_ack_d   = load;
    frame_done_d = 1'b0;
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    nibble       = 4'h0;
    an_onehot    = '0;

    last_cnt = (cnt_q == CW'(DWELL - 1));
    last_idx = (idx_q == IW'(NDIG - 1));

    if (last_cnt) begin
      cnt_d = '0;
      idx_d = last_idx ? '0 : idx_q + IW'(1);
    end
    frame_done_d = last_cnt && last_idx;

    // frame_done_q high means this edge closes the frame: the only point active may change.
    if (load && frame_done_q) begin
      active_d  = digits_in;
      shadow_d  = digits_in;
      pending_d = 1'b0;
    end else begin
      if (load) begin
        shadow_d  = digits_in;
        pending_d = 1'b1;
      end
      if (frame_done_q && pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end

    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        nibble       = active_q[4*i +: 4];
        an_onehot[i] = 1'b1;
      end
    end

    // Outputs are registered, so the state seen at edge t sets the pins for cycle t.
    if (cnt_q >= CW'(BLANK)) begin
      an_d  = an_onehot ^ AN_OFF;
      seg_d = hex7(nibble) ^ SEG_OFF;
    end
  end

  // NOTE: digit buffers are reset too, so a reset never leaves stale data to reappear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (NDIG=4, DWELL=8, BLANK=2, active-low pins):
// a cycle model pushes expected pins per cycle, and they are popped at the falling edge.
module tb_seg7_scan_controller;

  localparam int NDIG  = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int FRAME = NDIG * DWELL;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [4*NDIG-1:0] digits_in = '0;
  logic              load_ack, frame_done;
  logic [NDIG-1:0]   an;
  logic [6:0]        seg;

  seg7_scan_controller #(
    .NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in),
    .load_ack(load_ack), .frame_done(frame_done), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [15:0] m_active, m_shadow;
  bit          m_pend, m_prev_load;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_hi(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tbl[d];
  endfunction

  // Holds reset for 5 cycles checking blanked pins, then releases mid-cycle so the
  // next rising edge is t=0.
  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_fd", 32'(frame_done), 32'h0);
      check("rst_ack", 32'(load_ack), 32'h0);
    end
    reset       = 1'b0;
    m_active    = '0;
    m_shadow    = '0;
    m_pend      = 1'b0;
    m_prev_load = 1'b0;
  endtask

  // Runs ncyc cycles with up to two loads (time -1 = unused); rst_at >= 0 asserts reset
  // asynchronously in that cycle and ends the session.
  task automatic run_session(input int ncyc, input int ta, input logic [15:0] va,
                             input int tb, input logic [15:0] vb, input int rst_at,
                             input bit rnd);
    exp_t e, got;
    int   pos, slot;
    bit   ld, fb;
    logic [15:0] din;
    do_reset();
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk);
      #1;
      if (t == rst_at) begin
        reset = 1'b1;
        load  = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg), 32'h7F);
        check("async_rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        return;
      end
      ld  = (t == ta) || (t == tb);
      din = (t == ta) ? va : ((t == tb) ? vb : 16'h0);
      if (rnd && ($urandom_range(0, 9) == 0)) begin
        ld  = 1'b1;
        din = 16'($urandom);
      end
      load      = ld;
      digits_in = din;

      pos  = t % DWELL;
      slot = (t % FRAME) / DWELL;
      fb   = ((t % FRAME) == FRAME - 1);
      e.an  = (pos < BLANK) ? 4'hF : ~(4'b0001 << slot);
      e.seg = (pos < BLANK) ? 7'h7F : ~seg_hi(m_active[slot*4 +: 4]);
      e.fd  = fb;
      e.ack = m_prev_load;
      sb_q.push_back(e);

      if (ld && fb) begin
        m_active = din;
        m_shadow = din;
        m_pend   = 1'b0;
      end else begin
        if (ld) begin
          m_shadow = din;
          m_pend   = 1'b1;
        end
        if (fb && m_pend) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
      end
      m_prev_load = ld;

      @(negedge clk);
      got = sb_q.pop_front();
      check($sformatf("an@t%0d", t), 32'(an), 32'(got.an));
      check($sformatf("seg@t%0d", t), 32'(seg), 32'(got.seg));
      check($sformatf("frame_done@t%0d", t), 32'(frame_done), 32'(got.fd));
      check($sformatf("load_ack@t%0d", t), 32'(load_ack), 32'(got.ack));
    end
    load = 1'b0;
  endtask

  initial begin
    // Free run, no loads, two full frames.
    run_session(64, -1, 16'h0, -1, 16'h0, -1, 1'b0);
    // Single load mid-frame: frame 0 keeps showing zeros, frame 1 shows 1234.
    run_session(64, 5, 16'h1234, -1, 16'h0, -1, 1'b0);
    // Two loads in one frame: the later one wins.
    run_session(64, 3, 16'hAAAA, 20, 16'h00F0, -1, 1'b0);
    // Load in the frame_done cycle bypasses straight to the active buffer.
    run_session(48, 31, 16'hBEEF, -1, 16'h0, -1, 1'b0);
    // Async reset in the middle of a driven slot, then a fresh timeline from zeros.
    run_session(40, 5, 16'h1234, -1, 16'h0, 13, 1'b0);
    run_session(16, -1, 16'h0, -1, 16'h0, -1, 1'b0);
    // Random loads across several frames.
    run_session(160, -1, 16'h0, -1, 16'h0, -1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
